// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl: single-outstanding load/store unit with an internal word RAM,
// configurable access latency, lane handling and error flagging.
module lsu_mem_ctrl #(
    parameter int          DEPTH     = 1024,
    parameter int          LATENCY   = 1,
    parameter logic [31:0] BASE_ADDR = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wen,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);
    localparam int          IDX_W    = $clog2(DEPTH);
    localparam logic [31:0] SPAN     = 32'(DEPTH * 4);
    localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        wen_q, wen_d;
    logic [2:0]  op_q, op_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        err_q, err_d;
    logic        resp_valid_q, resp_valid_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;
    logic        resp_err_q, resp_err_d;

    logic [31:0] mem [DEPTH];

    logic [31:0]      req_offset;
    logic             misaligned;
    logic             out_of_range;
    logic             illegal_op;
    logic             req_err;
    logic [IDX_W-1:0] word_idx;
    logic [31:0]      rd_word;
    logic [7:0]       rd_byte;
    logic [15:0]      rd_half;
    logic [31:0]      load_data;
    logic [31:0]      st_data;
    logic [3:0]       st_be;
    logic             commit;

    // Classify the incoming request so the error is captured with it at accept.
    always_comb begin
        req_offset   = req_addr - BASE_ADDR;
        misaligned   = ((req_op[1:0] == 2'd1) && req_addr[0]) ||
                       ((req_op[1:0] == 2'd2) && (req_addr[1:0] != 2'b00));
        out_of_range = (req_addr < BASE_ADDR) || (req_offset >= SPAN);
        if (req_wen) begin
            illegal_op = (req_op >= 3'd3);
        end else begin
            illegal_op = (req_op == 3'd3) || (req_op[2:1] == 2'b11);
        end
        req_err = misaligned || out_of_range || illegal_op;
    end

    // Lane extraction for loads and lane steering / byte enables for stores.
    always_comb begin
        word_idx = IDX_W'((addr_q - BASE_ADDR) >> 2);
        rd_word  = mem[word_idx];
        case (addr_q[1:0])
            2'd0:    rd_byte = rd_word[7:0];
            2'd1:    rd_byte = rd_word[15:8];
            2'd2:    rd_byte = rd_word[23:16];
            default: rd_byte = rd_word[31:24];
        endcase
        rd_half = addr_q[1] ? rd_word[31:16] : rd_word[15:0];
        case (op_q)
            3'd0:    load_data = {{24{rd_byte[7]}}, rd_byte};
            3'd1:    load_data = {{16{rd_half[15]}}, rd_half};
            3'd2:    load_data = rd_word;
            3'd4:    load_data = {24'd0, rd_byte};
            3'd5:    load_data = {16'd0, rd_half};
            default: load_data = 32'd0;
        endcase
        case (op_q[1:0])
            2'd0: begin
                st_data = {4{wdata_q[7:0]}};
                st_be   = 4'b0001 << addr_q[1:0];
            end
            2'd1: begin
                st_data = {2{wdata_q[15:0]}};
                st_be   = addr_q[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                st_data = wdata_q;
                st_be   = 4'b1111;
            end
        endcase
        commit = (state_q == WAIT) && (cnt_q == 4'd0);
    end

    // Next-state logic for the IDLE -> WAIT -> RESP handshake sequence.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        wen_d        = wen_q;
        op_d         = op_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        err_d        = err_q;
        resp_valid_d = resp_valid_q;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    wen_d   = req_wen;
                    op_d    = req_op;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    err_d   = req_err;
                    cnt_d   = CNT_INIT;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d      = RESP;
                    resp_valid_d = 1'b1;
                    resp_err_d   = err_q;
                    resp_rdata_d = (err_q || wen_q) ? 32'd0 : load_data;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_d      = IDLE;
                    resp_valid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control and response registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= 4'd0;
            wen_q        <= 1'b0;
            op_q         <= 3'd0;
            addr_q       <= 32'd0;
            wdata_q      <= 32'd0;
            err_q        <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'd0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            wen_q        <= wen_d;
            op_q         <= op_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            err_q        <= err_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
        end
    end

    // RAM write at the commit edge; a reset in the same cycle suppresses it.
    always_ff @(posedge clk) begin
        if (rst_n && commit && wen_q && !err_q) begin
            for (int i = 0; i < 4; i++) begin
                if (st_be[i]) begin
                    mem[word_idx][8*i +: 8] <= st_data[8*i +: 8];
                end
            end
        end
    end

    assign req_ready  = (state_q == IDLE);
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;

endmodule

// File: doc/lsu_mem_ctrl.md
Name: lsu_mem_ctrl

Overview:
Parametrised successor to the multicycle data-memory stage. It owns an internal word-organised RAM. It accepts one load or store at a time over a valid/ready request channel and returns data and status over a valid/ready response channel. Latency is configurable. It handles byte/half/word lane selection, sign/zero extension and store byte-enables, and flags misaligned, out-of-range and illegal-op accesses instead of performing them. It sits between the EXU and WBU of the multicycle core.

Parameters:
DEPTH, 1024, RAM size in 32-bit words; power of two, >= 4.
LATENCY, 1, cycles spent in WAIT before the access commits; legal range 1..15.
BASE_ADDR, 32'h8000_0000, byte address of word 0; must be DEPTH*4 aligned.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst_n  in  1  synchronous active-low reset.
req_valid  in  1  request present.
req_ready  out  1  request accepted when both req_valid and req_ready are high at the edge.
req_wen  in  1  1 = store, 0 = load.
req_op  in  3  funct3. Loads: 0 lb, 1 lh, 2 lw, 4 lbu, 5 lhu. Stores: 0 sb, 1 sh, 2 sw.
req_addr  in  32  byte address.
req_wdata  in  32  store data, right-aligned (sb uses [7:0], sh uses [15:0]).
resp_valid  out  1  response present.
resp_ready  in  1  response consumed when both resp_valid and resp_ready are high at the edge.
resp_rdata  out  32  extended load data; 0 for stores and on error.
resp_err  out  1  access rejected.

Behaviour:
- Reset (rst_n low at an edge):
  - state IDLE, counter 0, resp_valid 0, resp_rdata 0, resp_err 0, latched request fields 0.
  - RAM contents are not reset.
  - Reset overrides every other event in the same cycle.
- Single outstanding transaction.
  - req_ready = (state == IDLE); it depends on state only, never on req_valid.
  - No request is accepted while WAIT or RESP is active.
- FSM IDLE -> WAIT -> RESP -> IDLE:
  - IDLE: on request handshake, latch wen, op, addr, wdata and the computed err. Load counter with LATENCY-1. Go to WAIT.
  - WAIT: if counter != 0, decrement. If counter == 0, commit the access at this edge, register resp_rdata/resp_err, and go to RESP.
  - RESP: resp_valid = 1. resp_rdata and resp_err are held stable until the response handshake, then go to IDLE.
- Timing:
  - Request handshake at edge k -> resp_valid high immediately after edge k+LATENCY.
  - Earliest next request accept is at the edge after the response handshake, because req_ready rises once IDLE is re-entered.
- err is the OR of three conditions:
  - Misaligned: h-ops with addr[0] = 1; w-ops with addr[1:0] != 0.
  - Out of range: addr < BASE_ADDR, or (addr - BASE_ADDR) >= DEPTH*4. Compute the subtraction in 32 bits and treat an addr wrap below BASE_ADDR as out of range.
  - Illegal op: load op 3, 6 or 7; store op >= 3.
- On err:
  - No RAM write.
  - resp_rdata = 0, resp_err = 1.
  - The full LATENCY is still observed.
- Word index = (addr - BASE_ADDR) >> 2, using log2(DEPTH) bits. Lane select uses addr[1:0].
- Load: the word is read at the commit edge.
  - b: byte lane addr[1:0].
  - h: halfword lane addr[1] (bytes 0-1 or 2-3).
  - lb/lh sign-extend; lbu/lhu zero-extend; lw passes the word through.
- Store: write at the commit edge with byte enables.
  - sb: enable byte addr[1:0] with wdata[7:0] replicated to all lanes.
  - sh: enable bytes {addr[1],0} and {addr[1],1} with wdata[15:0].
  - sw: all four bytes.
  - Unselected bytes are unchanged. resp_rdata = 0, resp_err = 0.
- Request inputs are sampled only at the accept edge. Changes after acceptance have no effect.
- resp_ready held high in RESP: handshake completes in the first RESP cycle.
- resp_ready asserted outside RESP is ignored.
- Reset during WAIT at or before the commit edge: the pending store is not written and no response is issued.
- RAM is inferred as a simple synchronous array.

Test Plan:
1. LATENCY=1: sw 0xDEADBEEF to BASE+0x8, then lw BASE+0x8 -> resp_rdata 0xDEADBEEF, resp_err 0. resp_valid rises exactly 1 cycle after each accept. Store response rdata is 0.
2. After test 1:
   - lb BASE+0xB -> 0xFFFFFFDE
   - lbu BASE+0xB -> 0x000000DE
   - lh BASE+0x8 -> 0xFFFFBEEF
   - lhu BASE+0xA -> 0x0000DEAD
3. sb wdata 0x12345655 to BASE+0x9, then lw BASE+0x8 -> 0xDEAD55EF. sh wdata 0x0000CAFE to BASE+0xA, then lw -> 0xCAFE55EF.
4. Each of the following -> resp_err 1, resp_rdata 0; a subsequent lw of the affected words shows them unchanged:
   - lw BASE+0x2
   - sh BASE+0x1
   - lw BASE-4
   - lw BASE+DEPTH*4
   - load op 3
5. LATENCY=3, lw with resp_ready held low 5 cycles:
   - resp_valid rises 3 cycles after accept.
   - resp_rdata and resp_err stay stable; req_ready stays 0 throughout.
   - A back-to-back req_valid is accepted on the edge after the response handshake.
6. LATENCY=3, sw 0x11111111 to BASE+0x10 over old value 0xAAAAAAAA, with rst_n pulsed low in the second WAIT cycle:
   - Next cycle: req_ready 1, resp_valid 0.
   - Subsequent lw BASE+0x10 -> 0xAAAAAAAA.
